// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that drives a combinational ALU from flops, waits a settle
// window, then captures the result and derived status flags into a response channel.
module alu_op_sequencer #(
  parameter int N             = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic         req_cin,
  input  logic [3:0]   req_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_z,
  input  logic         alu_co,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_z,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         rsp_neg,
  output logic         rsp_ovf,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b1001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   alu_a_q, alu_a_d;
  logic [N-1:0]   alu_b_q, alu_b_d;
  logic           alu_cin_q, alu_cin_d;
  logic [3:0]     alu_sel_q, alu_sel_d;
  logic [N-1:0]   rsp_z_q, rsp_z_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_neg_q, rsp_neg_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_err_q, rsp_err_d;

  logic sel_ok;
  logic settle_done;
  logic carry_c;
  logic ovf_c;

  always_comb begin
    sel_ok = 1'b0;
    case (req_sel)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL: sel_ok = 1'b1;
      default:                                       sel_ok = 1'b0;
    endcase
  end

  assign settle_done = (cnt_q == CW'(SETTLE_CYCLES - 1));

  // Flags are derived from the operands actually presented to the ALU, not the request port.
  always_comb begin
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (alu_sel_q)
      OP_ADD: begin
        carry_c = alu_co;
        ovf_c   = (alu_a_q[N-1] == alu_b_q[N-1]) && (alu_z[N-1] != alu_a_q[N-1]);
      end
      OP_SUB: begin
        carry_c = alu_co;
        ovf_c   = (alu_a_q[N-1] != alu_b_q[N-1]) && (alu_z[N-1] != alu_a_q[N-1]);
      end
      OP_SLL:  carry_c = alu_co;
      default: begin
        carry_c = 1'b0;
        ovf_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_sel_d   = alu_sel_q;
    rsp_z_d     = rsp_z_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (sel_ok) begin
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_cin_d = req_cin;
            alu_sel_d = req_sel;
            cnt_d     = '0;
            state_d   = SETTLE;
          end else begin
            // Unsupported opcode: leave the ALU bus alone and answer with an error.
            rsp_z_d     = '0;
            rsp_carry_d = 1'b0;
            rsp_zero_d  = 1'b0;
            rsp_neg_d   = 1'b0;
            rsp_ovf_d   = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (settle_done) begin
          rsp_z_d     = alu_z;
          rsp_carry_d = carry_c;
          rsp_zero_d  = (alu_z == '0);
          rsp_neg_d   = alu_z[N-1];
          rsp_ovf_d   = ovf_c;
          rsp_err_d   = 1'b0;
          cnt_d       = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_sel_q   <= '0;
      rsp_z_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_sel_q   <= alu_sel_d;
      rsp_z_q     <= rsp_z_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU on the alu_* bus, a vector table with
// hand-computed responses queued on accept and checked on the response handshake.
module tb_alu_op_sequencer;
  localparam int N      = 4;
  localparam int SETTLE = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [N-1:0] req_a, req_b;
  logic         req_cin;
  logic [3:0]   req_sel;
  logic [N-1:0] alu_a, alu_b, alu_z;
  logic         alu_cin, alu_co;
  logic [3:0]   alu_sel;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_z;
  logic         rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err, busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_z(alu_z), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; logic ops drive co=1 so the sequencer must mask it.
  logic [N:0] sum;
  always_comb begin
    sum    = '0;
    alu_z  = '0;
    alu_co = 1'b0;
    case (alu_sel)
      4'b0000: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
        alu_z = sum[N-1:0]; alu_co = sum[N];
      end
      4'b0001: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
        alu_z = sum[N-1:0]; alu_co = sum[N];
      end
      4'b0011: begin alu_z = alu_a & alu_b; alu_co = 1'b1; end
      4'b0100: begin alu_z = alu_a | alu_b; alu_co = 1'b1; end
      4'b0101: begin alu_z = alu_a ^ alu_b; alu_co = 1'b1; end
      4'b1001: begin alu_z = {alu_a[N-2:0], 1'b0}; alu_co = alu_a[N-1]; end
      default: begin alu_z = '0; alu_co = 1'b0; end
    endcase
  end

  typedef struct {
    logic [3:0]   sel;
    logic [N-1:0] a, b;
    logic         cin;
    logic [N-1:0] z;
    logic         c, zr, ng, ov, er;
  } vec_t;

  typedef struct {
    logic [N-1:0] z;
    logic         c, zr, ng, ov, er;
  } exp_t;

  vec_t       vecs[12];
  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         txn = 0;
  logic [3:0] last_sel = 4'b0000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    @(negedge clk);
    req_a = v.a; req_b = v.b; req_cin = v.cin; req_sel = v.sel; req_valid = 1'b1;
  endtask

  // Waits for req_ready, queues the expected response, and checks the ALU bus after accept.
  task automatic accept(input vec_t v);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", int'(req_ready), 1);
    if (req_ready) begin
      exp_q.push_back('{z: v.z, c: v.c, zr: v.zr, ng: v.ng, ov: v.ov, er: v.er});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
      if (!v.er) begin
        chk("alu_a_latched", int'(alu_a), int'(v.a));
        chk("alu_sel_latched", int'(alu_sel), int'(v.sel));
        chk("rsp_valid_early", int'(rsp_valid), 0);
        last_sel = v.sel;
      end else begin
        chk("alu_sel_kept", int'(alu_sel), int'(last_sel));
      end
    end
  endtask

  // Called at the negedge after the accept edge; leaves us one edge after accept at least.
  task automatic wait_rsp(input logic err);
    int n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (err) begin
      chk("err_latency", int'(n <= 1), 1);
      if (n == 0) @(negedge clk);
      chk("err_valid_held", int'(rsp_valid), 1);
    end else begin
      chk("rsp_latency", n, SETTLE);
    end
  endtask

  task automatic take_rsp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk("rsp_valid", int'(rsp_valid), 1);
    chk("rsp_z", int'(rsp_z), int'(e.z));
    chk("rsp_carry", int'(rsp_carry), int'(e.c));
    chk("rsp_zero", int'(rsp_zero), int'(e.zr));
    chk("rsp_neg", int'(rsp_neg), int'(e.ng));
    chk("rsp_ovf", int'(rsp_ovf), int'(e.ov));
    chk("rsp_err", int'(rsp_err), int'(e.er));
    $display("txn %0d: z=%b c=%b zr=%b n=%b v=%b e=%b (exp z=%b c=%b zr=%b n=%b v=%b e=%b)",
             txn, rsp_z, rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err,
             e.z, e.c, e.zr, e.ng, e.ov, e.er);
    txn++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", int'(rsp_valid), 0);
    chk("req_ready_idle", int'(req_ready), 1);
  endtask

  task automatic run_vec(input vec_t v);
    drive_req(v);
    accept(v);
    wait_rsp(v.er);
    take_rsp();
  endtask

  initial begin
    //            sel      a        b        cin   z        c     zr    ng    ov    er
    vecs[0]  = '{4'b0000, 4'b0001, 4'b1010, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 4'b1011, 4'b0110, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0001, 4'b0110, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'b0101, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0100, 4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'b0011, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'b1001, 4'b1001, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0010, 4'b0101, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'b0001, 4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, 4'b1110, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; req_sel = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_alu_a", int'(alu_a), 0);
    chk("reset_rsp_z", int'(rsp_z), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Response back-pressure with a competing request waiting.
    drive_req(vecs[2]);
    accept(vecs[2]);
    wait_rsp(1'b0);
    req_a = vecs[4].a; req_b = vecs[4].b; req_cin = vecs[4].cin; req_sel = vecs[4].sel;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req_ready", int'(req_ready), 0);
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_z", int'(rsp_z), 32'b1011);
      chk("hold_rsp_ovf", int'(rsp_ovf), 1);
    end
    take_rsp();
    accept(vecs[4]);
    wait_rsp(1'b0);
    take_rsp();

    // Asynchronous reset in the middle of the settle window.
    drive_req(vecs[0]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    chk("arst_req_ready", int'(req_ready), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_alu_a", int'(alu_a), 0);
    chk("arst_alu_b", int'(alu_b), 0);
    chk("arst_alu_sel", int'(alu_sel), 0);
    chk("arst_alu_cin", int'(alu_cin), 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    last_sel = 4'b0000;
    run_vec(vecs[1]);
    run_vec(vecs[9]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
